// File: rtl/mem_bus_arbiter.sv
// Shares the memory controller port between the CPU (default owner) and one DMA master.
// A DMA access takes memory CPU_SLICE cycles after the request and is acked one cycle later; the CPU is stalled via c_busy.
module mem_bus_arbiter #(
    parameter int CPU_SLICE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_data_wr,
    input  logic        c_is_write,
    input  logic        c_lock,
    output logic [31:0] c_data_rd,
    output logic        c_busy,
    input  logic        d_req,
    input  logic        d_is_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data_wr,
    output logic        d_ack,
    output logic [31:0] d_data_rd,
    output logic [31:0] m_addr,
    output logic [31:0] m_data_wr,
    output logic        m_is_write,
    input  logic [31:0] m_data_rd,
    input  logic        m_busy,
    output logic        owner
);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_t;

    localparam logic [3:0] SAT_CNT = 4'(CPU_SLICE - 1);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] d_rd_q, d_rd_d;
    logic        grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_CPU;
            starve_q <= 4'd0;
            d_ack_q  <= 1'b0;
            d_rd_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            d_ack_q  <= d_ack_d;
            d_rd_q   <= d_rd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        d_ack_d  = 1'b0;
        d_rd_d   = d_rd_q;
        grant    = 1'b0;
        case (state_q)
            ST_CPU: begin
                grant = d_req && !d_ack_q && (starve_q == SAT_CNT)
                        && !m_busy && !c_is_write && !c_lock;
                if (grant) begin
                    state_d = ST_DMA;
                end
            end
            ST_DMA: begin
                state_d = ST_CPU;
                d_ack_d = 1'b1;
                if (!d_is_write) begin
                    d_rd_d = m_data_rd;
                end
            end
        endcase
        // The ack cycle counts as cycle 0 of a held request, so back-to-back accesses are CPU_SLICE+1 apart.
        if (!d_req || grant) begin
            starve_d = 4'd0;
        end else if (state_q == ST_CPU && starve_q != SAT_CNT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign owner      = (state_q == ST_DMA);
    assign m_addr     = owner ? d_addr     : c_addr;
    assign m_data_wr  = owner ? d_data_wr  : c_data_wr;
    assign m_is_write = owner ? d_is_write : c_is_write;
    assign c_busy     = owner ? 1'b1       : m_busy;
    assign c_data_rd  = m_data_rd;
    assign d_ack      = d_ack_q;
    assign d_data_rd  = d_rd_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timestamp-based grant model plus a transaction scoreboard.
module tb_mem_bus_arbiter;

    localparam int SLICE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_addr, c_data_wr;
    logic        c_is_write, c_lock;
    logic [31:0] c_data_rd;
    logic        c_busy;
    logic        d_req, d_is_write;
    logic [31:0] d_addr, d_data_wr;
    logic        d_ack;
    logic [31:0] d_data_rd;
    logic [31:0] m_addr, m_data_wr;
    logic        m_is_write;
    logic [31:0] m_data_rd;
    logic        m_busy;
    logic        owner;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_own_cyc = 0;
    int   issue_cyc = 0;

    mem_bus_arbiter #(.CPU_SLICE(SLICE)) dut (
        .clk(clk), .rst(rst),
        .c_addr(c_addr), .c_data_wr(c_data_wr), .c_is_write(c_is_write), .c_lock(c_lock),
        .c_data_rd(c_data_rd), .c_busy(c_busy),
        .d_req(d_req), .d_is_write(d_is_write), .d_addr(d_addr), .d_data_wr(d_data_wr),
        .d_ack(d_ack), .d_data_rd(d_data_rd),
        .m_addr(m_addr), .m_data_wr(m_data_wr), .m_is_write(m_is_write),
        .m_data_rd(m_data_rd), .m_busy(m_busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign m_data_rd = mem_rd(m_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: who owns memory, from request timestamps and blocking terms.
    bit ref_dma = 0, ref_ack = 0, prev_req = 0;
    int req_start = 0;
    always @(negedge clk) begin
        logic [31:0] ea;
        bit grant;
        if (!rst) begin
            ref_dma  = 0;
            ref_ack  = 0;
            prev_req = 0;
        end
        ea = ref_dma ? d_addr : c_addr;
        chk("owner", {31'd0, owner}, {31'd0, ref_dma});
        chk("d_ack", {31'd0, d_ack}, {31'd0, ref_ack});
        chk("c_busy", {31'd0, c_busy}, {31'd0, ref_dma ? 1'b1 : m_busy});
        chk("m_addr", m_addr, ea);
        chk("m_data_wr", m_data_wr, ref_dma ? d_data_wr : c_data_wr);
        chk("m_is_write", {31'd0, m_is_write}, {31'd0, ref_dma ? d_is_write : c_is_write});
        chk("c_data_rd", c_data_rd, mem_rd(ea));
        if (rst) begin
            if (d_req && (!prev_req || ref_ack)) req_start = cyc;
            grant = !ref_dma && d_req && !ref_ack && (cyc - req_start >= SLICE - 1)
                    && !m_busy && !c_is_write && !c_lock;
            prev_req = d_req;
            ref_ack  = ref_dma;
            ref_dma  = grant;
        end
    end

    // Scoreboard monitor: memory-side fields on each DMA cycle, read data on each ack.
    logic [31:0] exp_last_rd = 32'd0;
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_last_rd = 32'd0;
            chk("rst_d_data_rd", d_data_rd, 32'd0);
        end else begin
            if (owner) begin
                last_own_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: owner=1 at cycle %0d with no request outstanding", cyc);
                end else begin
                    chk("sb_m_addr", m_addr, exp_q[0].a);
                    chk("sb_m_is_write", {31'd0, m_is_write}, {31'd0, exp_q[0].w});
                    if (exp_q[0].w) chk("sb_m_data_wr", m_data_wr, exp_q[0].d);
                end
            end
            if (d_ack && exp_q.size() != 0) begin
                txn_t t;
                t = exp_q.pop_front();
                if (!t.w) exp_last_rd = t.rd;
                chk("sb_d_data_rd", d_data_rd, exp_last_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        d_req      = 1'b1;
        d_is_write = w;
        d_addr     = a;
        d_data_wr  = d;
        t.w = w; t.a = a; t.d = d; t.rd = mem_rd(a);
        exp_q.push_back(t);
        issue_cyc = cyc;
    endtask

    task automatic wait_ack(output int own_c, output int ack_c);
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (d_ack === 1'b1) begin
                got = 1;
                break;
            end
        end
        #1;
        ack_c = cyc;
        own_c = last_own_cyc;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no d_ack within 300 cycles, got none expected 1");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int own1, own2, ack1, i0;
        bit rand_done, seen;
        rst = 1'b0;
        c_addr = 32'h0000_0040; c_data_wr = 32'd0; c_is_write = 1'b0; c_lock = 1'b0;
        d_req = 1'b0; d_is_write = 1'b0; d_addr = 32'd0; d_data_wr = 32'd0;
        m_busy = 1'b0;
        repeat (2) @(negedge clk);
        step();
        rst = 1'b1;
        repeat (2) step();

        // Unblocked DMA read.
        issue(1'b0, 32'h0000_1000, 32'd0);
        i0 = issue_cyc;
        wait_ack(own1, ack1);
        chk("rd_own_latency", own1 - i0, SLICE);
        chk("rd_ack_latency", ack1 - i0, SLICE + 1);
        chk("rd_data", d_data_rd, 32'hDEAD_BEEF);
        step();
        d_req = 1'b0;
        repeat (2) step();

        // c_lock held for ten cycles blocks a DMA write.
        issue(1'b1, 32'h0000_2000, 32'h1234_5678);
        c_lock = 1'b1;
        i0 = issue_cyc;
        repeat (10) step();
        c_lock = 1'b0;
        wait_ack(own1, ack1);
        chk("lock_own", own1 - i0, 11);
        chk("lock_ack", ack1 - i0, 12);
        chk("lock_rd_held", d_data_rd, 32'hDEAD_BEEF);
        step();
        d_req = 1'b0;
        repeat (2) step();

        // CPU write in the saturation cycle, then two busy cycles from the controller.
        issue(1'b0, 32'h0000_0A00, 32'd0);
        i0 = issue_cyc;
        repeat (SLICE - 1) step();
        c_is_write = 1'b1; c_addr = 32'h0000_0500; c_data_wr = 32'hCAFE_0001;
        step();
        c_is_write = 1'b0; m_busy = 1'b1;
        repeat (2) step();
        m_busy = 1'b0;
        wait_ack(own1, ack1);
        chk("collide_own", own1 - i0, SLICE + 3);
        step();
        d_req = 1'b0;
        repeat (2) step();

        // Back-to-back: request held through the ack with a new address.
        issue(1'b0, 32'h0000_1000, 32'd0);
        wait_ack(own1, ack1);
        step();
        issue(1'b0, 32'h0000_3000, 32'd0);
        wait_ack(own2, ack1);
        chk("b2b_spacing", own2 - own1, SLICE + 1);
        chk("b2b_data", d_data_rd, mem_rd(32'h0000_3000));
        step();
        d_req = 1'b0;
        repeat (2) step();

        // Randomized traffic on both sides.
        rand_done = 0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    bit keep;
                    issue($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom);
                    wait_ack(own1, ack1);
                    keep = ($urandom_range(0, 2) == 0);
                    step();
                    if (!keep) begin
                        d_req = 1'b0;
                        repeat ($urandom_range(0, 3)) step();
                    end
                end
                d_req = 1'b0;
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    step();
                    c_addr     = $urandom;
                    c_data_wr  = $urandom;
                    c_is_write = ($urandom_range(0, 3) == 0);
                    c_lock     = ($urandom_range(0, 9) == 0);
                    m_busy     = ($urandom_range(0, 3) == 0);
                end
            end
        join
        step();
        c_is_write = 1'b0; c_lock = 1'b0; m_busy = 1'b0; c_addr = 32'h0000_0080;
        repeat (3) step();

        // Reset during the DMA cycle.
        issue(1'b0, 32'h0000_4444, 32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (owner === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("rst_mid_reached_dma", {31'd0, seen}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_owner_async", {31'd0, owner}, 32'd0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        step();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (d_ack === 1'b1) seen = 1;
        end
        chk("rst_mid_no_ack", {31'd0, seen}, 32'd0);
        chk("rst_mid_d_data_rd", d_data_rd, 32'd0);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
